dct_mac8: RTL

DCT_MAC8 -- requirements
Module: dct_mac8

---
 rtl/dct_pkg.sv | 29 ++
 rtl/dct_round_sat.sv | 50 +++++
 rtl/dct_mac8.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared DCT datapath package.
// Holds the fixed widths of the 8-term multiply-accumulate path, the
// accumulator type and the product sign-extension helper used by dct_mac8.
// SHIFT and OUT_W stay as module parameters because they differ per
// coefficient row. Everything else is fixed for the whole DCT.
package dct_pkg;

    // Accumulator width. 8 products of at most |255 * -128| = 32640
    // give at most 261120, which fits in 19 signed bits.
    localparam int ACC_W  = 19;
    // Width of the unsigned-8 x signed-8 product.
    localparam int PROD_W = 16;
    // Number of terms summed per coefficient.
    localparam int TERMS  = 8;
    // Width of the term counter (0 .. TERMS-1).
    localparam int CNT_W  = 3;

    // Counter value that identifies the final term of a block.
    localparam logic [CNT_W-1:0] LAST_TERM = 3'd7;

    // Signed accumulator value.
    typedef logic signed [ACC_W-1:0] acc_t;

    // Sign-extend a product to accumulator width.
    function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
        return {{(ACC_W - PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage : dct_pkg

// File: rtl/dct_round_sat.sv
// Round, shift and saturate an 8-term DCT sum into a coefficient.
// Purely combinational.
//   sum  : signed ACC_W-bit full-precision sum
//   coef : signed OUT_W-bit result
// Rounding adds 2^(SHIFT-1) before the arithmetic shift, so halves round
// toward +infinity (e.g. -64 >>> 7 gives 0, -65 gives -1). The result is
// then clamped to the signed OUT_W range. SHIFT must be at least 1.
module dct_round_sat
    import dct_pkg::*;
#(
    parameter int SHIFT = 7,
    parameter int OUT_W = 12
) (
    input  logic [ACC_W-1:0] sum,
    output logic [OUT_W-1:0] coef
);

    // One extra bit of headroom so the rounding bias can never wrap.
    localparam int EXT_W = ACC_W + 1;

    logic signed [EXT_W-1:0] sum_ext_s;
    logic signed [EXT_W-1:0] half_s;
    logic signed [EXT_W-1:0] biased_s;
    logic signed [EXT_W-1:0] shifted_s;
    logic signed [EXT_W-1:0] max_s;
    logic signed [EXT_W-1:0] min_s;

    assign sum_ext_s = {sum[ACC_W-1], sum};
    assign half_s    = EXT_W'(1) << (SHIFT - 1);
    assign biased_s  = sum_ext_s + half_s;
    // biased_s is signed, so >>> replicates the sign bit (floor division).
    assign shifted_s = biased_s >>> SHIFT;

    // Saturation bounds of the signed OUT_W result.
    assign max_s = (EXT_W'(1) << (OUT_W - 1)) - EXT_W'(1);
    assign min_s = -(EXT_W'(1) << (OUT_W - 1));

    // Clamp the shifted value to the representable output range.
    always_comb begin
        coef = shifted_s[OUT_W-1:0];
        if (shifted_s > max_s) begin
            coef = max_s[OUT_W-1:0];
        end else if (shifted_s < min_s) begin
            coef = min_s[OUT_W-1:0];
        end else begin
            coef = shifted_s[OUT_W-1:0];
        end
    end

endmodule : dct_round_sat

// File: rtl/dct_mac8.sv
// Eight-term DCT multiply-accumulate.
// Sums eight signed products per coefficient, then rounds, shifts and
// saturates the sum. The datapath has three parts:
//   - Accumulate : cnt_r/acc_r gather terms 0..7. The 8th term is added
//                  directly into sum_r, which frees the accumulator for the
//                  next block in the very next cycle.
//   - Stage 1    : sum_r holds the finished sum, and s1_valid_r flags it.
//   - Stage 2    : acc_out, coef and coef_valid are registered from sum_r.
// Ports:
//   clk, rst     : clock; synchronous active-high reset with top priority
//   prod_valid   : prod holds a term this cycle
//   prod         : signed 16-bit product
//   sync         : drop any partial sum; a same-cycle product becomes term 0
//   acc_out      : signed 19-bit full-precision sum
//   coef         : rounded, shifted, saturated signed coefficient
//   coef_valid   : one-cycle pulse qualifying acc_out/coef, two cycles after
//                  the 8th term
//   busy         : a partial sum holding 1..7 terms is pending
// A block already in stage 1 or stage 2 is not affected by sync. Reset
// discards everything, including results in flight.
module dct_mac8
    import dct_pkg::*;
#(
    parameter int SHIFT = 7,
    parameter int OUT_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prod_valid,
    input  logic [PROD_W-1:0] prod,
    input  logic              sync,
    output logic [ACC_W-1:0]  acc_out,
    output logic [OUT_W-1:0]  coef,
    output logic              coef_valid,
    output logic              busy
);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [ACC_W-1:0] acc_r;
    logic [ACC_W-1:0] acc_nxt_s;
    logic [ACC_W-1:0] prod_ext_s;
    logic [ACC_W-1:0] sum_nxt_s;
    logic [ACC_W-1:0] sum_r;
    logic             load_s;
    logic             s1_valid_r;
    logic [OUT_W-1:0] coef_s;

    // Two's-complement addition gives the same bits whether the operands
    // are read as signed or unsigned. No overflow is possible at 19 bits.
    assign prod_ext_s = sext_prod(prod);
    assign sum_nxt_s  = acc_r + prod_ext_s;

    // Next-state logic for the term counter and the accumulator.
    always_comb begin
        acc_nxt_s = acc_r;
        cnt_nxt_s = cnt_r;
        load_s    = 1'b0;
        if (prod_valid) begin
            if (sync || (cnt_r == 3'd0)) begin
                // First term of a block. A sync restarts the count here.
                acc_nxt_s = prod_ext_s;
                cnt_nxt_s = 3'd1;
            end else if (cnt_r == LAST_TERM) begin
                // 8th term: the sum moves to stage 1 and counting restarts.
                acc_nxt_s = {ACC_W{1'b0}};
                cnt_nxt_s = 3'd0;
                load_s    = 1'b1;
            end else begin
                acc_nxt_s = sum_nxt_s;
                cnt_nxt_s = cnt_r + 3'd1;
            end
        end else if (sync) begin
            acc_nxt_s = {ACC_W{1'b0}};
            cnt_nxt_s = 3'd0;
        end else begin
            // Gap between terms: hold the state.
            acc_nxt_s = acc_r;
            cnt_nxt_s = cnt_r;
        end
    end

    // Accumulator, term counter, stage-1 sum register and busy flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= 3'd0;
            acc_r      <= {ACC_W{1'b0}};
            sum_r      <= {ACC_W{1'b0}};
            s1_valid_r <= 1'b0;
            busy       <= 1'b0;
        end else begin
            cnt_r      <= cnt_nxt_s;
            acc_r      <= acc_nxt_s;
            s1_valid_r <= load_s;
            // Registering busy from the next count keeps busy equal to
            // (cnt_r != 0) every cycle.
            busy       <= (cnt_nxt_s != 3'd0);
            if (load_s) begin
                sum_r <= sum_nxt_s;
            end else begin
                sum_r <= sum_r;
            end
        end
    end

    dct_round_sat #(
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .sum  (sum_r),
        .coef (coef_s)
    );

    // Stage-2 output registers. They hold their values between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out    <= {ACC_W{1'b0}};
            coef       <= {OUT_W{1'b0}};
            coef_valid <= 1'b0;
        end else begin
            coef_valid <= s1_valid_r;
            if (s1_valid_r) begin
                acc_out <= sum_r;
                coef    <= coef_s;
            end else begin
                acc_out <= acc_out;
                coef    <= coef;
            end
        end
    end

endmodule : dct_mac8
